hello_uart_rx: RTL and testbench
================================

Name: hello_uart_rx

Overview:
- Serial receiver for the "Hello World" greeting; the receiving end of the greeting stream our banner modules emit.
- Deserializes an 8N1 UART line (LSB first) into bytes.
- Scans the byte stream for the fixed 11-byte message "Hello World" and counts matches.
- Sits between the board RX pin and the status/LED logic.

Parameters:
- CLKS_PER_BIT, 16: i_clock cycles per serial bit. Minimum 4; even values only.
- COUNT_W, 8: width of o_match_count.

Ports:
- i_clock  input  1  system clock; all logic on posedge.
- i_reset_n  input  1  synchronous reset, active-low.
- i_rx  input  1  asynchronous serial line; idles high.
- o_byte  output  8  last received byte; valid while o_byte_valid=1.
- o_byte_valid  output  1  one-cycle pulse per good frame.
- o_frame_err  output  1  one-cycle pulse when the stop bit samples low.
- o_match  output  1  one-cycle pulse when the final 'd' of "Hello World" completes a match.
- o_match_count  output  COUNT_W  saturating count of matches.
- o_busy  output  1  high whenever the RX FSM is not in IDLE.

Behaviour:
- Reset: one clock clock, one synchronous active-low reset (i_reset_n), sampled on posedge i_clock. While i_reset_n=0:
  - all outputs are 0, o_byte=8'h00, o_match_count=0;
  - both synchronizer flops are set to 1 and the FSM goes to IDLE.
  - Reset asserted mid-frame aborts the frame; no pulse is emitted.
- Synchronizer: i_rx passes through a 2-flop synchronizer (rx_s). All sampling uses rx_s.
- IDLE: when rx_s=0, go to START and clear the bit counter.
- START: at cycle CLKS_PER_BIT/2-1, sample rx_s.
  - If 0: go to DATA and clear the counter.
  - If 1: treat as a glitch and return to IDLE with no output.
- DATA: every CLKS_PER_BIT cycles, shift rx_s into bit[idx], LSB first. After bit 7, go to STOP.
- STOP: after CLKS_PER_BIT cycles, sample rx_s.
  - If 1: pulse o_byte_valid for one cycle, update o_byte, go to IDLE.
  - If 0: pulse o_frame_err, go to BREAK.
- BREAK: wait for rx_s=1, then go to IDLE. This prevents a held-low line from being decoded as repeated frames.
- Latency: o_byte_valid rises 9.5 bit periods + 3 cycles after the falling edge of i_rx. Bench tolerance is ±2 cycles.
- Back-to-back frames: a start bit beginning immediately after the stop bit is received without loss.
- Matcher: index midx runs 0..10 and is updated only on o_byte_valid cycles.
  - If byte==MSG[midx]: midx increments. If midx was 10, midx returns to 0 and o_match pulses on the next cycle.
  - Otherwise, if byte=="H", midx=1; else midx=0. This restart rule is exact because 'H' occurs once in the message.
  - o_frame_err forces midx=0.
- o_match_count increments on each o_match and saturates at 2^COUNT_W-1 (no wrap).
- Match comparison is case-sensitive; "hello World" does not match.

Optional Feature:
- Macro: HELLO_UART_RX_PARITY_EN.
- Defined:
  - Frame is 8E1: an even-parity bit follows bit 7 in a PARITY state.
  - Adds port o_parity_err (output, 1 bit).
  - On a parity mismatch with a good stop bit: o_parity_err pulses, o_byte_valid stays 0, midx=0.
  - Latency grows by one bit period.
- Undefined: 8N1 framing, no PARITY state, no o_parity_err port.

Decomposition:
- Package hello_pkg holds:
  - rx_state_t enum: IDLE, START, DATA, PARITY, STOP, BREAK;
  - MSG_LEN=11;
  - MSG byte array holding "Hello World";
  - bit-counter width function clog2.
- Sub-module hello_uart_rx_core contains the synchronizer, the FSM and the deserializer. It outputs byte, valid, frame_err and parity_err.
- The top level contains the matcher and the counter.

Test Plan:
- Reset: hold i_reset_n=0 for 5 cycles with i_rx=0 -> all outputs 0. After release with i_rx=1, o_busy=0.
- Single byte 8'h48 at CLKS_PER_BIT=16 -> one o_byte_valid with o_byte=8'h48 about 155 cycles after the start edge; o_match=0.
- Stream "xxHello World" -> exactly one o_match, after the 'd' byte, and o_match_count=1.
- Stream "HelHello World" -> one o_match, exercising the restart-on-'H' rule. Then "Hello Worle" -> no match, count stays 1.
- Stop bit driven low on the 3rd byte of "Hello World", line held low for 50 cycles -> one o_frame_err and no valid for that byte. midx resets; resending the full message gives a match.
- COUNT_W=2 with five messages -> o_match_count saturates at 3. With HELLO_UART_RX_PARITY_EN, a bad parity bit -> o_parity_err pulse and no o_byte_valid.

Source files
------------

// File: rtl/hello_pkg.sv
// Shared types and constants for the "Hello World" UART receiver.
// HELLO_UART_RX_PARITY_EN selects 8E1 framing in the core and top.
package hello_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_t;

  localparam int MSG_LEN = 11;

  localparam logic [7:0] MSG [MSG_LEN] = '{
    8'h48, 8'h65, 8'h6c, 8'h6c, 8'h6f, 8'h20,
    8'h57, 8'h6f, 8'h72, 8'h6c, 8'h64
  };

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/hello_uart_rx_core.sv
// Synchronizer, RX FSM and deserializer for 8N1 (8E1 with
// HELLO_UART_RX_PARITY_EN) serial frames.
module hello_uart_rx_core
  import hello_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       i_clock,
  input  logic       i_reset_n,
  input  logic       i_rx,
  output logic [7:0] o_byte,
  output logic       o_valid,
  output logic       o_frame_err,
  output logic       o_parity_err,
  output logic       o_busy
);

  localparam int CW = clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  logic            sync1_q;
  logic            sync2_q;
  logic            rx_s;
  rx_state_t       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      byte_q, byte_d;
  logic            valid_q, valid_d;
  logic            ferr_q, ferr_d;
  logic            perr_q, perr_d;
`ifdef HELLO_UART_RX_PARITY_EN
  logic            par_q, par_d;
`endif

  assign rx_s = sync2_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    shift_d = shift_q;
    byte_d  = byte_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    perr_d  = 1'b0;
`ifdef HELLO_UART_RX_PARITY_EN
    par_d   = par_q;
`endif
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = START;
      end
      START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          idx_d   = idx_q + 1'b1;
          if (idx_q == 3'd7) begin
`ifdef HELLO_UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef HELLO_UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          par_d   = rx_s;
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d = '0;
          if (rx_s) begin
            state_d = IDLE;
`ifdef HELLO_UART_RX_PARITY_EN
            if (par_q != ^shift_q) begin
              perr_d = 1'b1;
            end else begin
              valid_d = 1'b1;
              byte_d  = shift_q;
            end
`else
            valid_d = 1'b1;
            byte_d  = shift_q;
`endif
          end else begin
            ferr_d  = 1'b1;
            state_d = BREAK;
          end
        end
      end
      // A held-low line must return high before a new start is seen
      BREAK: begin
        cnt_d = '0;
        if (rx_s) state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      byte_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      perr_q  <= 1'b0;
`ifdef HELLO_UART_RX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      sync1_q <= i_rx;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      byte_q  <= byte_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      perr_q  <= perr_d;
`ifdef HELLO_UART_RX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign o_byte       = byte_q;
  assign o_valid      = valid_q;
  assign o_frame_err  = ferr_q;
  assign o_parity_err = perr_q;
  assign o_busy       = (state_q != IDLE);

endmodule

// File: rtl/hello_uart_rx.sv
// UART receiver that counts "Hello World" messages in the byte stream.
// HELLO_UART_RX_PARITY_EN adds even parity and the o_parity_err port.
module hello_uart_rx
  import hello_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int COUNT_W      = 8
) (
  input  logic               i_clock,
  input  logic               i_reset_n,
  input  logic               i_rx,
  output logic [7:0]         o_byte,
  output logic               o_byte_valid,
  output logic               o_frame_err,
  output logic               o_match,
  output logic [COUNT_W-1:0] o_match_count,
  output logic               o_busy
`ifdef HELLO_UART_RX_PARITY_EN
  ,
  output logic               o_parity_err
`endif
);

  localparam logic [3:0] LAST = 4'(MSG_LEN - 1);

  logic [7:0]         rx_byte;
  logic               rx_valid;
  logic               rx_ferr;
  logic               rx_perr;
  logic [3:0]         midx_q, midx_d;
  logic               match_q, match_d;
  logic [COUNT_W-1:0] count_q, count_d;

  hello_uart_rx_core #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_core (
    .i_clock      (i_clock),
    .i_reset_n    (i_reset_n),
    .i_rx         (i_rx),
    .o_byte       (rx_byte),
    .o_valid      (rx_valid),
    .o_frame_err  (rx_ferr),
    .o_parity_err (rx_perr),
    .o_busy       (o_busy)
  );

  // 'H' appears once in the message, so restarting on 'H' is exact
  always_comb begin
    midx_d  = midx_q;
    match_d = 1'b0;
    count_d = count_q;
    if (rx_ferr || rx_perr) begin
      midx_d = '0;
    end else if (rx_valid) begin
      if (rx_byte == MSG[midx_q]) begin
        if (midx_q == LAST) begin
          midx_d  = '0;
          match_d = 1'b1;
          if (count_q != {COUNT_W{1'b1}}) begin
            count_d = count_q + 1'b1;
          end
        end else begin
          midx_d = midx_q + 1'b1;
        end
      end else if (rx_byte == MSG[0]) begin
        midx_d = 4'd1;
      end else begin
        midx_d = '0;
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      midx_q  <= '0;
      match_q <= 1'b0;
      count_q <= '0;
    end else begin
      midx_q  <= midx_d;
      match_q <= match_d;
      count_q <= count_d;
    end
  end

  assign o_byte        = rx_byte;
  assign o_byte_valid  = rx_valid;
  assign o_frame_err   = rx_ferr;
  assign o_match       = match_q;
  assign o_match_count = count_q;
`ifdef HELLO_UART_RX_PARITY_EN
  assign o_parity_err  = rx_perr;
`endif

endmodule

// File: tb/tb_hello_uart_rx.sv
// Directed + randomized bench for hello_uart_rx against a message-level
// reference model; HELLO_UART_RX_PARITY_EN enables the parity checks.
module tb_hello_uart_rx;

  localparam int CPB = 16;
  localparam int CW  = 2;
  localparam int SAT = (1 << CW) - 1;
`ifdef HELLO_UART_RX_PARITY_EN
  localparam int LAT = CPB * 19 / 2 + 3 + CPB;
`else
  localparam int LAT = CPB * 19 / 2 + 3;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx = 1'b0;
  logic [7:0]    dbyte;
  logic          dvalid;
  logic          ferr;
  logic          match;
  logic [CW-1:0] mcount;
  logic          busy;
`ifdef HELLO_UART_RX_PARITY_EN
  logic          perr;
`endif

  always #5 clk = ~clk;

  hello_uart_rx #(
    .CLKS_PER_BIT (CPB),
    .COUNT_W      (CW)
  ) dut (
    .i_clock       (clk),
    .i_reset_n     (rst_n),
    .i_rx          (rx),
    .o_byte        (dbyte),
    .o_byte_valid  (dvalid),
    .o_frame_err   (ferr),
    .o_match       (match),
    .o_match_count (mcount),
    .o_busy        (busy)
`ifdef HELLO_UART_RX_PARITY_EN
    ,
    .o_parity_err  (perr)
`endif
  );

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic [7:0] rx_q[$];
  int n_valid = 0, n_ferr = 0, n_match = 0, n_perr = 0, n_bad_match = 0;
  int last_valid_cyc = 0;
  logic prev_v = 1'b0;
  logic [7:0] prev_b = 8'h00;

  always @(negedge clk) begin
    if (dvalid === 1'b1) begin
      rx_q.push_back(dbyte);
      n_valid++;
      last_valid_cyc = cyc;
    end
    if (ferr === 1'b1) n_ferr++;
`ifdef HELLO_UART_RX_PARITY_EN
    if (perr === 1'b1) n_perr++;
`endif
    if (match === 1'b1) begin
      n_match++;
      if (!(prev_v === 1'b1 && prev_b == 8'h64)) n_bad_match++;
    end
    prev_v = dvalid;
    prev_b = dbyte;
  end

  // Reference: a match is "Hello World" ending the bytes seen since the
  // last match or error; every good frame is expected on o_byte.
  string MSG = "Hello World";
  logic [7:0] exp_q[$];
  logic [7:0] hist[$];
  int m_matches = 0;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_good(input logic [7:0] b);
    bit eq;
    exp_q.push_back(b);
    hist.push_back(b);
    if (hist.size() >= 11) begin
      eq = 1'b1;
      for (int i = 0; i < 11; i++)
        if (hist[hist.size() - 11 + i] != 8'(MSG.getc(i))) eq = 1'b0;
      if (eq) begin
        m_matches++;
        hist.delete();
      end
    end
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop_ok,
                            input bit par_ok);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef HELLO_UART_RX_PARITY_EN
    send_bit((^b) ^ !par_ok);
`else
    if (!par_ok) $display("note: parity not built in");
`endif
    if (stop_ok) begin
      send_bit(1'b1);
    end else begin
      rx = 1'b0;
      repeat (CPB + 50) @(posedge clk);
      #1;
      rx = 1'b1;
      repeat (2 * CPB) @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int gap;
    send_frame(b, 1'b1, 1'b1);
    model_good(b);
    gap = $urandom_range(0, 12);
    if (gap > 6) gap = 0;
    repeat (gap) @(posedge clk);
    #1;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(8'(s.getc(i)));
  endtask

  task automatic settle();
    repeat (4 * CPB) @(posedge clk);
    #1;
  endtask

  task automatic check_stream(input string tag);
    int n;
    chk({tag, "_nbytes"}, rx_q.size(), exp_q.size());
    n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      chk({tag, "_byte"}, int'(rx_q[i]), int'(exp_q[i]));
    chk({tag, "_matches"}, n_match, m_matches);
    chk({tag, "_count"}, int'(mcount),
        (m_matches > SAT) ? SAT : m_matches);
    chk({tag, "_match_after_d"}, n_bad_match, 0);
  endtask

  initial begin
    int t0;
    int lat;
    int nv;
    int nf;
    int np;

    rst_n = 1'b0;
    rx = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_valid", int'(dvalid), 0);
    chk("rst_byte", int'(dbyte), 0);
    chk("rst_ferr", int'(ferr), 0);
    chk("rst_match", int'(match), 0);
    chk("rst_count", int'(mcount), 0);
    chk("rst_busy", int'(busy), 0);
    rx = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("idle_busy", int'(busy), 0);

    // single byte with latency measurement
    t0 = cyc;
    send_frame(8'h48, 1'b1, 1'b1);
    model_good(8'h48);
    settle();
    lat = last_valid_cyc - t0;
    chk("single_nvalid", n_valid, 1);
    chk("single_latency_ok", int'(lat >= LAT - 2 && lat <= LAT + 2), 1);
    check_stream("single");

    // glitch on the line is ignored
    nv = n_valid;
    rx = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rx = 1'b1;
    @(posedge clk);
    #1;
    chk("glitch_busy_hi", int'(busy), 1);
    settle();
    chk("glitch_busy_lo", int'(busy), 0);
    chk("glitch_nvalid", n_valid, nv);

    // random noise prefix then the message
    send_str("xx");
    repeat ($urandom_range(3, 6)) send_byte(8'($urandom_range(0, 255)));
    send_str("Hello World");
    settle();
    check_stream("prefix");

    send_str("HelHello World");
    settle();
    check_stream("restart_h");

    send_str("Hello Worle");
    send_str("hello World");
    settle();
    check_stream("near_miss");

    // framing error on the third byte
    nf = n_ferr;
    nv = n_valid;
    send_str("He");
    send_frame(8'h6c, 1'b0, 1'b1);
    hist.delete();
    settle();
    chk("ferr_pulses", n_ferr - nf, 1);
    chk("ferr_nvalid", n_valid - nv, 2);
    chk("ferr_busy", int'(busy), 0);
    send_str("Hello World");
    settle();
    check_stream("after_ferr");

`ifdef HELLO_UART_RX_PARITY_EN
    np = n_perr;
    nv = n_valid;
    send_str("Hello Wor");
    send_frame(8'h6c, 1'b1, 1'b0);
    hist.delete();
    send_byte(8'h64);
    settle();
    chk("perr_pulses", n_perr - np, 1);
    chk("perr_nvalid", n_valid - nv, 10);
    check_stream("parity");
`else
    np = n_perr;
    chk("no_perr", np, 0);
`endif

    // saturation
    repeat (5) send_str("Hello World");
    settle();
    check_stream("saturate");
    chk("sat_value", int'(mcount), SAT);

    // reset mid-frame aborts silently
    nv = n_valid;
    nf = n_ferr;
    rx = 1'b0;
    repeat (3 * CPB) @(posedge clk);
    #1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rx = 1'b1;
    rst_n = 1'b1;
    repeat (12 * CPB) @(posedge clk);
    #1;
    chk("midrst_nvalid", n_valid, nv);
    chk("midrst_nferr", n_ferr, nf);
    chk("midrst_count", int'(mcount), 0);
    chk("midrst_busy", int'(busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
